serial_pattern_gen: RTL and testbench

Parametrised successor to the fixed-sequence serial generator. It emits a run-time programmable bit pattern of 1..MAX_LEN bits on a single serial output, MSB of the active length first. It supports one-shot and continuous-repeat modes, start/stop control, and per-pass framing flags. It sits wherever a fixed serial preamble or test sequence was previously hard-coded.

---
 rtl/serial_pattern_gen_if.sv | 27 ++
 rtl/serial_pattern_gen.sv | 102 ++++++++++
 tb/tb_serial_pattern_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if: config, run control and serial output bundle for serial_pattern_gen
interface serial_pattern_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_repeat;
  logic               start;
  logic               stop;
  logic               out;
  logic               out_valid;
  logic               first;
  logic               last;
  logic               busy;
  logic               done;
  logic               cfg_err;
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_repeat, start, stop,
    input  out, out_valid, first, last, busy, done, cfg_err
  );
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_repeat, start, stop,
    output out, out_valid, first, last, busy, done, cfg_err
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: programmable 1..MAX_LEN bit serial pattern, MSB of active length first
module serial_pattern_gen #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'h00D5,
  parameter int                 RST_LEN     = 8,
  parameter logic               RST_REPEAT  = 1'b0
) (
  input logic                  clk,
  input logic                  reset_n,
  serial_pattern_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_state_n;
  logic [MAX_LEN-1:0] r_pattern, r_run_pattern, w_src;
  logic [LEN_W-1:0]   r_len, r_run_len, r_idx, w_idx_n;
  logic               r_repeat, r_run_repeat;
  logic               r_out, r_valid, r_first, r_last, r_busy, r_done, r_cfg_err;
  logic               w_out_n, w_valid_n, w_first_n, w_last_n, w_done_n;
  logic               w_load, w_cfg_ok;
  assign w_cfg_ok = bus.cfg_we && r_state == IDLE && bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(MAX_LEN);
  // a run starts from the stored config; later passes use the copy latched at start
  assign w_src = (r_state == IDLE) ? r_pattern : r_run_pattern;
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_valid_n = 1'b0;
    w_first_n = 1'b0;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE: if (bus.start && !bus.stop) begin
        w_state_n = RUN;
        w_idx_n   = r_len - 1'b1;
        w_valid_n = 1'b1;
        w_first_n = 1'b1;
        w_load    = 1'b1;
      end
      RUN: if (bus.stop) w_state_n = IDLE;
      else if (r_idx != '0) begin
        w_idx_n   = r_idx - 1'b1;
        w_valid_n = 1'b1;
      end else if (r_run_repeat) begin
        w_idx_n   = r_run_len - 1'b1;
        w_valid_n = 1'b1;
        w_first_n = 1'b1;
      end else begin
        w_state_n = DONE;
        w_done_n  = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
    w_last_n = w_valid_n && w_idx_n == '0;
    w_out_n  = w_valid_n && |(w_src & ({{(MAX_LEN-1){1'b0}}, 1'b1} << w_idx_n));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_pattern     <= RST_PATTERN;
      r_len         <= LEN_W'(RST_LEN);
      r_repeat      <= RST_REPEAT;
      r_run_pattern <= RST_PATTERN;
      r_run_len     <= LEN_W'(RST_LEN);
      r_run_repeat  <= RST_REPEAT;
      r_out         <= 1'b0;
      r_valid       <= 1'b0;
      r_first       <= 1'b0;
      r_last        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_out     <= w_out_n;
      r_valid   <= w_valid_n;
      r_first   <= w_first_n;
      r_last    <= w_last_n;
      r_busy    <= w_valid_n;
      r_done    <= w_done_n;
      r_cfg_err <= bus.cfg_we && !w_cfg_ok;
      if (w_load) begin
        r_run_pattern <= r_pattern;
        r_run_len     <= r_len;
        r_run_repeat  <= r_repeat;
      end
      if (w_cfg_ok) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= bus.cfg_len;
        r_repeat  <= bus.cfg_repeat;
      end
    end
  end
  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.first     = r_first;
  assign bus.last      = r_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: directed and random stimulus against a queue-based pattern model
module tb_serial_pattern_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  serial_pattern_gen_if #(.MAX_LEN(16)) bus ();
  serial_pattern_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  bit [15:0]  m_pat;
  int         m_len;
  bit         m_rep;
  bit [15:0]  run_pat;
  int         run_len;
  bit         run_rep;
  bit         running, in_done, e_err, e_done;
  logic [2:0] q[$];
  logic [15:0] cap;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_pat = 16'h00D5; m_len = 8; m_rep = 1'b0;
    running = 0; in_done = 0; e_err = 0; e_done = 0;
    q.delete();
  endtask
  // one pass = list of {bit, first, last}, most significant active bit first
  task automatic fill();
    for (int i = run_len - 1; i >= 0; i--) q.push_back({run_pat[i], i == run_len - 1, i == 0});
  endtask
  task automatic model_edge(input bit we, input logic [15:0] pat, input int len, input bit rep, input bit st, input bit sp);
    bit idle, ok;
    idle = !running && !in_done;
    ok = we && idle && len >= 1 && len <= 16;
    e_err = we && !ok;
    e_done = 0;
    if (in_done) in_done = 0;
    else if (!running) begin
      if (st && !sp) begin
        run_pat = m_pat; run_len = m_len; run_rep = m_rep;
        fill();
        running = 1;
      end
    end else if (sp) begin
      q.delete();
      running = 0;
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (run_rep) fill();
        else begin running = 0; e_done = 1; in_done = 1; end
      end
    end
    if (ok) begin m_pat = pat; m_len = len; m_rep = rep; end
  endtask
  function automatic logic [15:0] got_vec();
    return {9'b0, bus.out, bus.out_valid, bus.first, bus.last, bus.busy, bus.done, bus.cfg_err};
  endfunction
  function automatic logic [15:0] exp_vec();
    logic [2:0] h;
    h = running ? q[0] : 3'b000;
    return {9'b0, h[2], running, h[1], h[0], running, e_done, e_err};
  endfunction
  task automatic cyc(input bit we = 0, input logic [15:0] pat = 0, input int len = 0,
                     input bit rep = 0, input bit st = 0, input bit sp = 0);
    bus.cfg_we = we; bus.cfg_pattern = pat; bus.cfg_len = len[4:0];
    bus.cfg_repeat = rep; bus.start = st; bus.stop = sp;
    @(posedge clk);
    #1;
    model_edge(we, pat, len, rep, st, sp);
    chk("outputs", got_vec(), exp_vec());
    if (bus.out_valid) cap = {cap[14:0], bus.out};
    bus.cfg_we = 0; bus.start = 0; bus.stop = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0;
    bus.cfg_repeat = 0; bus.start = 0; bus.stop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", got_vec(), 16'h0);
    reset_n = 1'b1;
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(9);
    chk("rst_pattern_bits", cap, 16'h00D5);
    cyc(1, 16'h0005, 3, 1);
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(6);
    cyc(0, 0, 0, 0, 0, 1);
    chk("repeat_bits", cap, 16'h005B);
    idle(2);
    cyc(1, 16'hFFFF, 0, 0);
    cyc(1, 16'hFFFF, 17, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h000F, 4, 0);
    idle(4);
    cyc(0, 0, 0, 0, 0, 1);
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1);
    chk("cfg_kept_bits", cap, 16'h0005);
    cyc(1, 16'hA5F0, 16, 0);
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(18);
    chk("max_len_bits", cap, 16'hA5F0);
    cyc(1, 16'hFFF1, 1, 0);
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(3);
    chk("len1_bits", cap, 16'h0001);
    cyc(1, 16'h0033, 6, 1);
    cyc(0, 0, 0, 0, 1);
    idle(3);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", got_vec(), 16'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(9);
    chk("post_reset_bits", cap, 16'h00D5);
    cap = 0;
    cyc(1, 16'h0001, 2, 0, 1);
    idle(9);
    chk("old_cfg_bits", cap, 16'h00D5);
    cap = 0;
    cyc(0, 0, 0, 0, 1);
    idle(3);
    chk("new_cfg_bits", cap, 16'h0001);
    cyc(0, 0, 0, 0, 1, 1);
    idle(2);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(7) == 0, 16'($urandom), int'($urandom_range(17)), 1'($urandom_range(1)),
          $urandom_range(3) == 0, $urandom_range(15) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
